// File: rtl/fila_escrita_reg.sv
// Write-back queue in front of the register file: a 4-deep FIFO drained one
// entry per cycle into registered write ports, with hazard lookup/forwarding.
module fila_escrita_reg #(
    parameter int BITS = 63
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            entrada_valida,
    output logic            entrada_pronta,
    input  logic [4:0]      entrada_endereco,
    input  logic [BITS:0]   entrada_dado,
    output logic            permisao_escrita,
    output logic [4:0]      endereco_regd,
    output logic [BITS:0]   dado_escrita,
    input  logic [4:0]      consulta_end1,
    input  logic [4:0]      consulta_end2,
    output logic            pendente1,
    output logic            pendente2,
    output logic [BITS:0]   valor_pend1,
    output logic [BITS:0]   valor_pend2,
    output logic [2:0]      ocupacao
);

    localparam int DEPTH = 4;

    logic [4:0]     end_mem  [0:DEPTH-1];
    logic [BITS:0]  dado_mem [0:DEPTH-1];

    logic [1:0]     head_reg, head_next;
    logic [1:0]     tail_reg, tail_next;
    logic [2:0]     count_reg, count_next;
    logic           perm_reg, perm_next;
    logic [4:0]     end_out_reg, end_out_next;
    logic [BITS:0]  dado_out_reg, dado_out_next;

    logic           push;
    logic           pop;

    assign entrada_pronta = (count_reg < 3'(DEPTH)) && reset_n;

    // Writes to x0 are accepted handshake-wise but never reach the queue.
    assign push = entrada_valida && entrada_pronta && (entrada_endereco != 5'd0);
    assign pop  = (count_reg != 3'd0);

    always_comb begin
        head_next     = head_reg;
        tail_next     = tail_reg;
        count_next    = count_reg + 3'(push) - 3'(pop);
        perm_next     = pop;
        end_out_next  = end_out_reg;
        dado_out_next = dado_out_reg;
        if (push) begin
            tail_next = tail_reg + 2'd1;
        end
        if (pop) begin
            head_next     = head_reg + 2'd1;
            end_out_next  = end_mem[head_reg];
            dado_out_next = dado_mem[head_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head_reg     <= 2'd0;
            tail_reg     <= 2'd0;
            count_reg    <= 3'd0;
            perm_reg     <= 1'b0;
            end_out_reg  <= 5'd0;
            dado_out_reg <= '0;
        end else begin
            head_reg     <= head_next;
            tail_reg     <= tail_next;
            count_reg    <= count_next;
            perm_reg     <= perm_next;
            end_out_reg  <= end_out_next;
            dado_out_reg <= dado_out_next;
        end
    end

    // Storage needs no reset: validity is tracked solely by head/count.
    always_ff @(posedge clk) begin
        if (push) begin
            end_mem[tail_reg]  <= entrada_endereco;
            dado_mem[tail_reg] <= entrada_dado;
        end
    end

    assign permisao_escrita = perm_reg;
    assign endereco_regd    = end_out_reg;
    assign dado_escrita     = dado_out_reg;
    assign ocupacao         = count_reg;

    logic [4:0]    consulta [0:1];
    logic          pend_q   [0:1];
    logic [BITS:0] valor_q  [0:1];

    assign consulta[0] = consulta_end1;
    assign consulta[1] = consulta_end2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_consulta
            logic [1:0] slot;

            // Oldest source first so later (younger) matches override earlier ones.
            always_comb begin
                pend_q[gi]  = 1'b0;
                valor_q[gi] = '0;
                slot        = head_reg;
                if (consulta[gi] != 5'd0) begin
                    if (perm_reg && (end_out_reg == consulta[gi])) begin
                        pend_q[gi]  = 1'b1;
                        valor_q[gi] = dado_out_reg;
                    end
                    for (int p = 0; p < DEPTH; p++) begin
                        slot = head_reg + 2'(p);
                        if ((3'(p) < count_reg) && (end_mem[slot] == consulta[gi])) begin
                            pend_q[gi]  = 1'b1;
                            valor_q[gi] = dado_mem[slot];
                        end
                    end
                end
            end
        end
    endgenerate

    assign pendente1   = pend_q[0];
    assign pendente2   = pend_q[1];
    assign valor_pend1 = valor_q[0];
    assign valor_pend2 = valor_q[1];

endmodule
